// File: rtl/neuron_pkg.sv
// Shared types, default sizes and the clip helper for the neuron MAC slice.
package neuron_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_N_INPUTS = 4;
  localparam int DEF_ACC_W    = 20;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUT
  } state_t;

  // Clips a sign-extended value into the signed range of a dw-bit word.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] val,
                                                  input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (val > hi) return hi;
    else if (val < lo) return lo;
    else return val;
  endfunction

endpackage

// File: rtl/neuron_sat.sv
// Output stage: clips the accumulator to DATA_W and flags clipping.
// Optional ReLU on the clipped value when NEURON_MAC_RELU_EN is defined.
module neuron_sat
  import neuron_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                     en,
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] accu,
  output logic                     sat
);

  logic signed [63:0] wide;
  logic signed [63:0] clipped;

  assign wide    = 64'(acc);
  assign clipped = saturate(wide, DATA_W);

  // Outputs read as zero unless a result is being presented; sat reflects the clip only.
  always_comb begin
    accu = '0;
    sat  = 1'b0;
    if (en) begin
      sat  = (clipped != wide);
      accu = clipped[DATA_W-1:0];
`ifdef NEURON_MAC_RELU_EN
      if (clipped < 0) accu = '0;
`else
      accu = clipped[DATA_W-1:0];
`endif
    end
  end

endmodule

// File: rtl/neuron_mac.sv
// Neuron multiply-accumulate: bias plus N_INPUTS x*weight beats, saturated result.
// Build option NEURON_MAC_RELU_EN enables ReLU in the output stage.
module neuron_mac
  import neuron_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int N_INPUTS = DEF_N_INPUTS,
  parameter int ACC_W    = DEF_ACC_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] bias,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] weight,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] accu,
  output logic                     sat,
  output logic                     busy
);

  localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

  state_t                    state;
  state_t                    nextState;
  logic signed [ACC_W-1:0]   acc;
  logic        [CNT_W-1:0]   cnt;
  logic signed [2*DATA_W-1:0] prod;
  logic                      beat;
  logic                      lastBeat;

  assign prod     = x * weight;
  assign beat     = (state == ACCUM) && in_valid;
  assign lastBeat = (cnt == CNT_W'(N_INPUTS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = ACCUM;
      ACCUM:   if (beat && lastBeat) nextState = OUT;
      OUT:     if (out_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // The accumulator is wide enough that the full sum never wraps; clipping happens only at the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (state == IDLE && start) begin
      acc <= ACC_W'(bias);
      cnt <= '0;
    end else if (beat) begin
      acc <= acc + ACC_W'(prod);
      cnt <= cnt + 1'b1;
    end
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);

  neuron_sat #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_sat (
    .en  (out_valid),
    .acc (acc),
    .accu(accu),
    .sat (sat)
  );

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: vector table plus reset/ignore corner sequences.
module tb_neuron_mac;

  typedef struct {
    string name;
    int    bias;
    int    x0, x1, x2, x3;
    int    w0, w1, w2, w3;
    int    gap;
    int    hold;
    bit    midStart;
    int    expAccu;
    bit    expSat;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic signed [7:0] bias = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [7:0] x = '0;
  logic signed [7:0] weight = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic signed [7:0] accu;
  logic              sat;
  logic              busy;

  int   total = 0;
  int   bad = 0;
  vec_t vecs[$];

  neuron_mac #(
    .DATA_W  (8),
    .N_INPUTS(4),
    .ACC_W   (20)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bias     (bias),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .weight   (weight),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .accu     (accu),
    .sat      (sat),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d", name, actual, expected);
    end
  endtask

  task automatic addVec(input string name, input int b,
                        input int x0, input int x1, input int x2, input int x3,
                        input int w0, input int w1, input int w2, input int w3,
                        input int gap, input int hold, input bit midStart,
                        input int expAccu, input bit expSat);
    vec_t v;
    v.name = name; v.bias = b;
    v.x0 = x0; v.x1 = x1; v.x2 = x2; v.x3 = x3;
    v.w0 = w0; v.w1 = w1; v.w2 = w2; v.w3 = w3;
    v.gap = gap; v.hold = hold; v.midStart = midStart;
`ifdef NEURON_MAC_RELU_EN
    v.expAccu = (expAccu < 0) ? 0 : expAccu;
`else
    v.expAccu = expAccu;
`endif
    v.expSat = expSat;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    int xs[4];
    int ws[4];
    int edges;
    xs = '{v.x0, v.x1, v.x2, v.x3};
    ws = '{v.w0, v.w1, v.w2, v.w3};
    edges = 0;
    @(negedge clk);
    start = 1'b1;
    bias  = 8'(v.bias);
    @(negedge clk); edges++;
    start = 1'b0;
    bias  = 8'sd0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        for (int g = 0; g < v.gap; g++) begin
          in_valid = 1'b0;
          x = 8'sd99; weight = 8'sd99;
          @(negedge clk); edges++;
          checkOutput({v.name, "/gapReady"}, int'(in_ready), 1);
          checkOutput({v.name, "/gapBusy"}, int'(busy), 1);
        end
      end
      checkOutput({v.name, "/beatReady"}, int'(in_ready), 1);
      checkOutput({v.name, "/beatNoValid"}, int'(out_valid), 0);
      in_valid = 1'b1;
      x      = 8'(xs[i]);
      weight = 8'(ws[i]);
      if (v.midStart && i == 2) begin
        start = 1'b1;
        bias  = 8'sd50;
      end
      @(negedge clk); edges++;
      start = 1'b0;
      bias  = 8'sd0;
    end
    in_valid = 1'b1;
    x = 8'sd100; weight = 8'sd100;
    checkOutput({v.name, "/outValid"}, int'(out_valid), 1);
    checkOutput({v.name, "/latency"}, edges, 5 + 3 * v.gap);
    for (int h = 0; h < v.hold; h++) begin
      checkOutput({v.name, "/holdAccu"}, int'(accu), v.expAccu);
      checkOutput({v.name, "/holdSat"}, int'(sat), int'(v.expSat));
      checkOutput({v.name, "/holdValid"}, int'(out_valid), 1);
      checkOutput({v.name, "/holdBusy"}, int'(busy), 1);
      checkOutput({v.name, "/holdNoReady"}, int'(in_ready), 0);
      @(negedge clk);
    end
    checkOutput({v.name, "/accu"}, int'(accu), v.expAccu);
    checkOutput({v.name, "/sat"}, int'(sat), int'(v.expSat));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    start     = 1'b1;
    bias      = 8'sd99;
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    bias      = 8'sd0;
    checkOutput({v.name, "/doneValid"}, int'(out_valid), 0);
    checkOutput({v.name, "/doneIdle"}, int'(busy), 0);
  endtask

  initial begin
    addVec("basic",    1,    5,   0,  0,  0,    2,   3, 3, 3,  0, 0, 1'b0,   11, 1'b0);
    addVec("satPos",   0,  127, 127,127,127,  127, 127,127,127, 0, 0, 1'b0,  127, 1'b1);
    addVec("satNeg",  -128,-128,-128,-128,-128, 127,127,127,127, 0, 0, 1'b0, -128, 1'b1);
    addVec("mixed",   10,   -3,   4, 10, -2,    7,  -5, 2, 9,  0, 1, 1'b0,  -29, 1'b0);
    addVec("edgeHi",  -1, -128,   0,  0,  0,   -1,   0, 0, 0,  0, 0, 1'b0,  127, 1'b0);
    addVec("overHi",   0, -128,   0,  0,  0,   -1,   0, 0, 0,  0, 0, 1'b0,  127, 1'b1);
    addVec("edgeLo", -128,   0,   0,  0,  0,    0,   0, 0, 0,  0, 0, 1'b0, -128, 1'b0);
    addVec("overLo",  -1, -128,   0,  0,  0,    1,   0, 0, 0,  0, 0, 1'b0, -128, 1'b1);
    addVec("backpres",-5,    1,   2,  3,  4,    1,   1, 1, 1,  2, 3, 1'b0,    5, 1'b0);
    addVec("ignStart", 3,    2,   2,  2,  2,    3,   3, 3, 3,  0, 0, 1'b1,   27, 1'b0);
    addVec("relu",   -20,    0,   0,  0,  0,    5,   5, 5, 5,  0, 2, 1'b0,  -20, 1'b0);

    #3;
    checkOutput("rstValid", int'(out_valid), 0);
    checkOutput("rstReady", int'(in_ready), 0);
    checkOutput("rstBusy", int'(busy), 0);
    checkOutput("rstAccu", int'(accu), 0);
    checkOutput("rstSat", int'(sat), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Beats offered while idle must be refused and leave no trace in the next result.
    in_valid = 1'b1; x = 8'sd100; weight = 8'sd100;
    @(negedge clk);
    checkOutput("idleReady", int'(in_ready), 0);
    checkOutput("idleBusy", int'(busy), 0);
    @(negedge clk);
    in_valid = 1'b0;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Abort an evaluation after two beats with an asynchronous reset.
    @(negedge clk);
    start = 1'b1; bias = 8'sd7;
    @(negedge clk);
    start = 1'b0; bias = 8'sd0;
    in_valid = 1'b1; x = 8'sd10; weight = 8'sd10;
    @(negedge clk);
    @(negedge clk);
    checkOutput("preRstBusy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midRstReady", int'(in_ready), 0);
    checkOutput("midRstBusy", int'(busy), 0);
    checkOutput("midRstValid", int'(out_valid), 0);
    checkOutput("midRstAccu", int'(accu), 0);
    checkOutput("midRstSat", int'(sat), 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postRstBusy", int'(busy), 0);
    begin
      vec_t r;
      r.name = "afterRst"; r.bias = 0;
      r.x0 = 1; r.x1 = 1; r.x2 = 1; r.x3 = 1;
      r.w0 = 1; r.w1 = 1; r.w2 = 1; r.w3 = 1;
      r.gap = 0; r.hold = 1; r.midStart = 1'b0;
      r.expAccu = 4; r.expSat = 1'b0;
      applyStimulus(r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
